// File: rtl/hqm_rcfwl_gclk_rcb_en_ctrl.sv
// RCB leaf clock-enable sequencer: arbitrates NUM_REQ clock requesters,
// sequences RcbEn through wake latency and idle hysteresis, and owns the
// RCB LCP pulse-shaping bits (Fd/Rd), which only change while gated off.
// Ports:
//   CkGridX1N, RstB (async, active low)
//   ReqIn/AckOut     per-requester level request / stable-clock grant
//   HystCfg          idle cycles held before gating (N gives N+1 HYST cycles)
//   CfgValid/CfgFdIn/CfgRdIn/CfgAck   LCP bit load handshake
//   RcbEn, Fd, Rd    RCB controls
//   ClkActive, State status (OFF=0 WAKE=1 ON=2 HYST=3)
// Optional: `define HQM_RCFWL_GCLK_RCB_FORCE_ON_EN adds ForceOn (DFX
// override that holds the clock on like a request and blocks config).
module hqm_rcfwl_gclk_rcb_en_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int HYST_W   = 4,
  parameter int WAKE_LAT = 2
) (
  input  logic               CkGridX1N,
  input  logic               RstB,
  input  logic [NUM_REQ-1:0] ReqIn,
  output logic [NUM_REQ-1:0] AckOut,
  input  logic [HYST_W-1:0]  HystCfg,
  input  logic               CfgValid,
  input  logic               CfgFdIn,
  input  logic               CfgRdIn,
  output logic               CfgAck,
  output logic               RcbEn,
  output logic               Fd,
  output logic               Rd,
  output logic               ClkActive,
`ifdef HQM_RCFWL_GCLK_RCB_FORCE_ON_EN
  input  logic               ForceOn,
`endif
  output logic [1:0]         State
);

  localparam int WAKE_W = (WAKE_LAT > 2) ? $clog2(WAKE_LAT) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LD = WAKE_W'(WAKE_LAT - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_HYST = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic [HYST_W-1:0]   hyst_cnt_q, hyst_cnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                cfg_ack_q, cfg_ack_d;
  logic                fd_q, fd_d;
  logic                rd_q, rd_d;

  logic force_on;
  logic any_req;
  logic cfg_take;
  logic ack_ok;

`ifdef HQM_RCFWL_GCLK_RCB_FORCE_ON_EN
  assign force_on = ForceOn;
`else
  assign force_on = 1'b0;
`endif

  assign any_req = (|ReqIn) | force_on;

  // cfg_ack_q blocks a second load while the requester is still
  // dropping CfgValid, so CfgAck stays a single-cycle pulse.
  assign cfg_take = (state_q == S_OFF) & CfgValid
                  & ~cfg_ack_q & ~force_on;

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    hyst_cnt_d = hyst_cnt_q;
    cfg_ack_d  = 1'b0;
    fd_d       = fd_q;
    rd_d       = rd_q;
    unique case (state_q)
      S_OFF: begin
        if (cfg_take) begin
          fd_d      = CfgFdIn;
          rd_d      = CfgRdIn;
          cfg_ack_d = 1'b1;
        end else if (any_req) begin
          state_d    = S_WAKE;
          wake_cnt_d = WAKE_LD;
        end
      end
      S_WAKE: begin
        if (wake_cnt_q == '0) begin
          state_d = S_ON;
        end else begin
          wake_cnt_d = wake_cnt_q - 1'b1;
        end
      end
      S_ON: begin
        if (!any_req) begin
          state_d    = S_HYST;
          hyst_cnt_d = HystCfg;
        end
      end
      S_HYST: begin
        if (any_req) begin
          state_d = S_ON;
        end else if (hyst_cnt_q == '0) begin
          state_d = S_OFF;
        end else begin
          hyst_cnt_d = hyst_cnt_q - 1'b1;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Grant only when the next state has a stable, running clock.
  assign ack_ok = (state_d == S_ON)
                | ((state_d == S_HYST) & any_req);
  assign ack_d  = ReqIn & {NUM_REQ{ack_ok}};

  always_ff @(posedge CkGridX1N or negedge RstB) begin
    if (!RstB) begin
      state_q    <= S_OFF;
      wake_cnt_q <= '0;
      hyst_cnt_q <= '0;
      ack_q      <= '0;
      cfg_ack_q  <= 1'b0;
      fd_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      hyst_cnt_q <= hyst_cnt_d;
      ack_q      <= ack_d;
      cfg_ack_q  <= cfg_ack_d;
      fd_q       <= fd_d;
      rd_q       <= rd_d;
    end
  end

  assign State     = state_q;
  assign RcbEn     = (state_q != S_OFF);
  assign ClkActive = (state_q == S_ON) | (state_q == S_HYST);
  assign AckOut    = ack_q;
  assign CfgAck    = cfg_ack_q;
  assign Fd        = fd_q;
  assign Rd        = rd_q;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_rcb_en_ctrl.sv
// Directed testbench for hqm_rcfwl_gclk_rcb_en_ctrl (default build,
// NUM_REQ=4, HYST_W=4, WAKE_LAT=2).
module tb_hqm_rcfwl_gclk_rcb_en_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] ack;
  logic [3:0] hyst_cfg;
  logic       cfg_valid;
  logic       cfg_fd;
  logic       cfg_rd;
  logic       cfg_ack;
  logic       rcb_en;
  logic       fd;
  logic       rd;
  logic       clk_active;
  logic [1:0] state;

  int checks;
  int failures;

  hqm_rcfwl_gclk_rcb_en_ctrl #(
    .NUM_REQ (4),
    .HYST_W  (4),
    .WAKE_LAT(2)
  ) dut (
    .CkGridX1N(clk),
    .RstB     (rst_n),
    .ReqIn    (req),
    .AckOut   (ack),
    .HystCfg  (hyst_cfg),
    .CfgValid (cfg_valid),
    .CfgFdIn  (cfg_fd),
    .CfgRdIn  (cfg_rd),
    .CfgAck   (cfg_ack),
    .RcbEn    (rcb_en),
    .Fd       (fd),
    .Rd       (rd),
    .ClkActive(clk_active),
    .State    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_off(input string name);
    int n;
    n = 0;
    while (state !== 2'd0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL %s_timeout state=%0d exp=0", name, state);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({state, rcb_en, ack, cfg_ack, clk_active, fd, rd} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs st=%0d en=%b ack=%b cack=%b act=%b fd=%b rd=%b exp=all0",
               state, rcb_en, ack, cfg_ack, clk_active, fd, rd);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (state !== 2'd0 || rcb_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset st=%0d en=%b exp=0/0", state, rcb_en);
    end
  endtask

  task automatic test_wake();
    logic [1:0] exp_st [4];
    exp_st = '{2'd0, 2'd1, 2'd1, 2'd2};
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (state !== exp_st[c]) begin
        failures++;
        $display("FAIL wake_state_c%0d got=%0d exp=%0d", c, state, exp_st[c]);
      end
      checks++;
      if (rcb_en !== (c >= 1)) begin
        failures++;
        $display("FAIL wake_rcben_c%0d got=%b exp=%b", c, rcb_en, c >= 1);
      end
      checks++;
      if (ack !== ((c == 3) ? 4'b0001 : 4'b0000) ||
          clk_active !== (c == 3)) begin
        failures++;
        $display("FAIL wake_ack_c%0d ack=%b act=%b exp_on=%b", c, ack, clk_active, c == 3);
      end
      if (c < 3) tick();
    end
  endtask

  task automatic test_hyst();
    req = 4'b0000;
    tick();
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL hyst_ack_drop got=%b exp=0000", ack);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== 2'd3 || rcb_en !== 1'b1) begin
        failures++;
        $display("FAIL hyst_cycle%0d st=%0d en=%b exp=3/1", i, state, rcb_en);
      end
      tick();
    end
    checks++;
    if (state !== 2'd0 || rcb_en !== 1'b0 || clk_active !== 1'b0) begin
      failures++;
      $display("FAIL hyst_gate_off st=%0d en=%b act=%b exp=0/0/0", state, rcb_en, clk_active);
    end
  endtask

  task automatic test_hyst_return();
    req = 4'b0001;
    repeat (3) tick();
    req = 4'b0000;
    tick();
    tick();
    tick();
    checks++;
    if (state !== 2'd3) begin
      failures++;
      $display("FAIL ret_in_hyst got=%0d exp=3", state);
    end
    req = 4'b0100;
    tick();
    checks++;
    if (state !== 2'd2 || ack !== 4'b0100 || rcb_en !== 1'b1) begin
      failures++;
      $display("FAIL ret_to_on st=%0d ack=%b en=%b exp=2/0100/1", state, ack, rcb_en);
    end
    tick();
    checks++;
    if (state !== 2'd2 || ack !== 4'b0100) begin
      failures++;
      $display("FAIL ret_hold st=%0d ack=%b exp=2/0100", state, ack);
    end
    req = 4'b0000;
    wait_off("ret");
  endtask

  task automatic test_cfg_in_on();
    req = 4'b0001;
    repeat (3) tick();
    cfg_valid = 1'b1;
    cfg_fd    = 1'b1;
    cfg_rd    = 1'b0;
    tick();
    tick();
    req = 4'b0000;
    for (int n = 0; n < 20 && state !== 2'd0; n++) begin
      checks++;
      if (cfg_ack !== 1'b0 || fd !== 1'b0 || rd !== 1'b0) begin
        failures++;
        $display("FAIL cfg_live_n%0d cack=%b fd=%b rd=%b exp=0/0/0", n, cfg_ack, fd, rd);
      end
      tick();
    end
    checks++;
    if (state !== 2'd0 || cfg_ack !== 1'b0) begin
      failures++;
      $display("FAIL cfg_first_off st=%0d cack=%b exp=0/0", state, cfg_ack);
    end
    tick();
    checks++;
    if (cfg_ack !== 1'b1 || fd !== 1'b1 || rd !== 1'b0 || rcb_en !== 1'b0) begin
      failures++;
      $display("FAIL cfg_load cack=%b fd=%b rd=%b en=%b exp=1/1/0/0", cfg_ack, fd, rd, rcb_en);
    end
    cfg_valid = 1'b0;
    tick();
    checks++;
    if (cfg_ack !== 1'b0 || fd !== 1'b1) begin
      failures++;
      $display("FAIL cfg_pulse cack=%b fd=%b exp=0/1", cfg_ack, fd);
    end
  endtask

  task automatic test_back_to_back();
    cfg_valid = 1'b1;
    cfg_fd    = 1'b0;
    cfg_rd    = 1'b1;
    req       = 4'b1000;
    tick();
    checks++;
    if (state !== 2'd0 || cfg_ack !== 1'b1 || fd !== 1'b0 || rd !== 1'b1) begin
      failures++;
      $display("FAIL b2b_cfg st=%0d cack=%b fd=%b rd=%b exp=0/1/0/1", state, cfg_ack, fd, rd);
    end
    cfg_valid = 1'b0;
    tick();
    checks++;
    if (state !== 2'd1 || cfg_ack !== 1'b0 || rcb_en !== 1'b1) begin
      failures++;
      $display("FAIL b2b_wake st=%0d cack=%b en=%b exp=1/0/1", state, cfg_ack, rcb_en);
    end
    tick();
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_early_ack got=%b exp=0000", ack);
    end
    tick();
    checks++;
    if (state !== 2'd2 || ack !== 4'b1000) begin
      failures++;
      $display("FAIL b2b_ack st=%0d ack=%b exp=2/1000", state, ack);
    end
  endtask

  task automatic test_reset_mid_hyst();
    req = 4'b0000;
    tick();
    checks++;
    if (state !== 2'd3 || rd !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre st=%0d rd=%b exp=3/1", state, rd);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || rcb_en !== 1'b0 || ack !== 4'b0000 ||
        fd !== 1'b0 || rd !== 1'b0 || clk_active !== 1'b0) begin
      failures++;
      $display("FAIL rst_async st=%0d en=%b ack=%b fd=%b rd=%b act=%b exp=all0",
               state, rcb_en, ack, fd, rd, clk_active);
    end
    req = 4'b0010;
    tick();
    rst_n = 1'b1;
    checks++;
    if (state !== 2'd0) begin
      failures++;
      $display("FAIL rst_release st=%0d exp=0", state);
    end
    tick();
    checks++;
    if (state !== 2'd1 || rcb_en !== 1'b1) begin
      failures++;
      $display("FAIL rst_rewake st=%0d en=%b exp=1/1", state, rcb_en);
    end
    tick();
    tick();
    checks++;
    if (state !== 2'd2 || ack !== 4'b0010) begin
      failures++;
      $display("FAIL rst_reack st=%0d ack=%b exp=2/0010", state, ack);
    end
  endtask

  task automatic test_wake_no_abort();
    req      = 4'b0000;
    hyst_cfg = 4'd0;
    wait_off("noab_pre");
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("FAIL noab_wake st=%0d exp=1", state);
    end
    tick();
    checks++;
    if (state !== 2'd2 || ack !== 4'b0000) begin
      failures++;
      $display("FAIL noab_on st=%0d ack=%b exp=2/0000", state, ack);
    end
    tick();
    checks++;
    if (state !== 2'd3) begin
      failures++;
      $display("FAIL hyst0_one st=%0d exp=3", state);
    end
    tick();
    checks++;
    if (state !== 2'd0 || rcb_en !== 1'b0) begin
      failures++;
      $display("FAIL hyst0_off st=%0d en=%b exp=0/0", state, rcb_en);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req       = 4'b0000;
    hyst_cfg  = 4'd3;
    cfg_valid = 1'b0;
    cfg_fd    = 1'b0;
    cfg_rd    = 1'b0;
    tick();
    tick();
    test_reset();
    test_wake();
    test_hyst();
    test_hyst_return();
    test_cfg_in_on();
    test_back_to_back();
    test_reset_mid_hyst();
    test_wake_no_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
